keypad_scanner: RTL and testbench

Parametrised matrix-keypad scanner and encoder for ROWS×COLS keypads. It drives active-low column strobes in a fixed rotation and samples active-low row inputs through a synchroniser. Whole-frame results are debounced and encoded, and each accepted press produces one code with a one-cycle strobe. Released keys and multi-key (ghosting) frames are reported separately. It sits between the keypad pins and the display/control logic, and it also generates the column counter that the fixed 4×4 encoder took as an input.

---
 rtl/keypad_pkg.sv | 26 ++
 rtl/keypad_if.sv | 39 +++
 rtl/keypad_scan_timer.sv | 73 +++++++
 rtl/keypad_scanner.sv | 215 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared definitions for the matrix-keypad scanner:
//     - debounce FSM state encoding (plain localparam constants)
//     - per-frame scan result encoding
//     - width helper used to size codes and counters
package keypad_pkg;

  // Debounce FSM states. ST_ prefix keeps them clear of the DEBOUNCE parameter.
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_PRESSED  = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  // Outcome of one complete scan frame.
  typedef enum logic [1:0] {
    RES_NONE   = 2'd0,
    RES_SINGLE = 2'd1,
    RES_MULTI  = 2'd2
  } frame_res_e;

  // Bits needed to index n items; never less than one bit.
  function automatic int code_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/keypad_if.sv
// keypad_if
//   Bundles the keypad pins and the encoded key outputs.
//   Ports (by modport):
//     master (scanner) : in row_n; out col_n, key_code, key_valid, key_held, multi_key
//     slave  (keypad / consumer side) : the mirror image
interface keypad_if
  import keypad_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int CODE_W = code_width(ROWS * COLS)
) ();

  logic [ROWS-1:0]   row_n;
  logic [COLS-1:0]   col_n;
  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              key_held;
  logic              multi_key;

  modport master (
    input  row_n,
    output col_n,
    output key_code,
    output key_valid,
    output key_held,
    output multi_key
  );

  modport slave (
    output row_n,
    input  col_n,
    input  key_code,
    input  key_valid,
    input  key_held,
    input  multi_key
  );

endinterface

// File: rtl/keypad_scan_timer.sv
// keypad_scan_timer
//   Column rotation timing. Each column is driven for SCAN_DIV cycles; the
//   column index advances when the dwell counter wraps.
//   Ports:
//     clock, reset : clock, asynchronous active-high reset
//     col_n        : one-hot active-low column strobes (registered)
//     col_idx      : index of the column currently strobed
//     sample_en    : last dwell cycle of the current column
//     frame_end    : last dwell cycle of column COLS-1
module keypad_scan_timer
  import keypad_pkg::*;
#(
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 16,
  localparam int COL_W   = code_width(COLS),
  localparam int DWELL_W = code_width(SCAN_DIV)
) (
  input  logic             clock,
  input  logic             reset,
  output logic [COLS-1:0]  col_n,
  output logic [COL_W-1:0] col_idx,
  output logic             sample_en,
  output logic             frame_end
);

  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [COLS-1:0]    col_n_q, col_n_d;
  logic               last_dwell_s;
  logic               last_col_s;

  assign last_dwell_s = (dwell_q == DWELL_W'(SCAN_DIV - 1));
  assign last_col_s   = (col_q == COL_W'(COLS - 1));

  // Next dwell/column and the strobe pattern for the next column.
  always_comb begin
    dwell_d = dwell_q;
    col_d   = col_q;
    if (last_dwell_s) begin
      dwell_d = '0;
      if (last_col_s) begin
        col_d = '0;
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end else begin
      dwell_d = dwell_q + DWELL_W'(1);
    end
    // Strobe is registered together with the index so both change on the same edge.
    for (int c = 0; c < COLS; c++) begin
      col_n_d[c] = (COL_W'(c) != col_d);
    end
  end

  // Timer state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dwell_q <= '0;
      col_q   <= '0;
      col_n_q <= ~(COLS'(1'b1));
    end else begin
      dwell_q <= dwell_d;
      col_q   <= col_d;
      col_n_q <= col_n_d;
    end
  end

  assign col_n     = col_n_q;
  assign col_idx   = col_q;
  assign sample_en = last_dwell_s;
  assign frame_end = last_dwell_s & last_col_s;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Matrix keypad scanner/encoder. Strobes columns, synchronises the rows,
//   accumulates one frame of hits, classifies the frame and debounces it.
//   Ports:
//     clock, reset : clock, asynchronous active-high reset
//     kp (master)  : row_n in; col_n, key_code, key_valid, key_held, multi_key out
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 16,
  parameter int DEBOUNCE = 3
) (
  input  logic     clock,
  input  logic     reset,
  keypad_if.master kp
);

  localparam int CODE_W = code_width(ROWS * COLS);
  localparam int COL_W  = code_width(COLS);
  localparam int CNT_W  = code_width(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE);

  logic [COLS-1:0]   col_n_s;
  logic [COL_W-1:0]  col_idx_s;
  logic              sample_en_s;
  logic              frame_end_s;

  logic [ROWS-1:0]   row_meta_q, row_sync_q;
  logic [1:0]        hit_cnt_q, hit_cnt_d;
  logic [CODE_W-1:0] hit_code_q, hit_code_d;
  logic [1:0]        acc_cnt_s;
  logic [CODE_W-1:0] acc_code_s;
  frame_res_e        res_s;

  logic [1:0]        state_q, state_d;
  logic [CODE_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc_s;
  logic [CODE_W-1:0] key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              key_held_q, key_held_d;
  logic              multi_key_q, multi_key_d;

  keypad_scan_timer #(
    .COLS     (COLS),
    .SCAN_DIV (SCAN_DIV)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .col_n     (col_n_s),
    .col_idx   (col_idx_s),
    .sample_en (sample_en_s),
    .frame_end (frame_end_s)
  );

  // Two-flop synchroniser; idle (all ones) out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
    end else begin
      row_meta_q <= kp.row_n;
      row_sync_q <= row_meta_q;
    end
  end

  // Frame totals including the column being sampled this cycle.
  always_comb begin
    acc_cnt_s  = hit_cnt_q;
    acc_code_s = hit_code_q;
    for (int r = 0; r < ROWS; r++) begin
      if (!row_sync_q[r]) begin
        acc_cnt_s  = (acc_cnt_s == 2'd2) ? 2'd2 : acc_cnt_s + 2'd1;
        acc_code_s = CODE_W'(r * COLS) + CODE_W'(col_idx_s);
      end else begin
        acc_cnt_s  = acc_cnt_s;
      end
    end
    case (acc_cnt_s)
      2'd0:    res_s = RES_NONE;
      2'd1:    res_s = RES_SINGLE;
      default: res_s = RES_MULTI;
    endcase
  end

  // Accumulators load on each column sample and clear after evaluation.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    hit_code_d = hit_code_q;
    if (frame_end_s) begin
      hit_cnt_d  = 2'd0;
      hit_code_d = '0;
    end else if (sample_en_s) begin
      hit_cnt_d  = acc_cnt_s;
      hit_code_d = acc_code_s;
    end else begin
      hit_cnt_d  = hit_cnt_q;
    end
  end

  assign cnt_inc_s = cnt_q + CNT_W'(1);

  // Debounce FSM; only moves on a frame evaluation.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    multi_key_d = multi_key_q;
    if (frame_end_s) begin
      multi_key_d = (res_s == RES_MULTI);
      case (state_q)
        ST_IDLE: begin
          if (res_s == RES_SINGLE) begin
            cand_d = acc_code_s;
            cnt_d  = CNT_W'(1);
            if (DEBOUNCE == 1) begin
              state_d     = ST_PRESSED;
              key_code_d  = acc_code_s;
              key_valid_d = 1'b1;
            end else begin
              state_d = ST_DEBOUNCE;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DEBOUNCE: begin
          if ((res_s == RES_SINGLE) && (acc_code_s == cand_q)) begin
            cnt_d = cnt_inc_s;
            if (cnt_inc_s == DEB_MAX) begin
              state_d     = ST_PRESSED;
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
            end else begin
              state_d = ST_DEBOUNCE;
            end
          end else if (res_s == RES_SINGLE) begin
            // A different single key restarts the count on the new candidate.
            cand_d = acc_code_s;
            cnt_d  = CNT_W'(1);
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_PRESSED: begin
          // No rollover: any activity keeps the accepted key down.
          if (res_s == RES_NONE) begin
            cnt_d = CNT_W'(1);
            if (DEBOUNCE == 1) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            state_d = ST_PRESSED;
          end
        end
        ST_RELEASE: begin
          if (res_s == RES_NONE) begin
            cnt_d = cnt_inc_s;
            if (cnt_inc_s == DEB_MAX) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            // Bounce during release: back to pressed without a new strobe.
            state_d = ST_PRESSED;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    key_held_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE);
  end

  // Scan accumulators, FSM state and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_cnt_q   <= 2'd0;
      hit_code_q  <= '0;
      state_q     <= ST_IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      multi_key_q <= 1'b0;
    end else begin
      hit_cnt_q   <= hit_cnt_d;
      hit_code_q  <= hit_code_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      multi_key_q <= multi_key_d;
    end
  end

  assign kp.col_n     = col_n_s;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;
  assign kp.multi_key = multi_key_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Bench for keypad_scanner with ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=3.
//   A simple keypad model pulls rows low for pressed keys in the strobed
//   column. Key sets change only at frame starts; a frame-level reference
//   model (streak counting) predicts outputs, checked every cycle, and a
//   table of hand-derived per-frame results is checked as well.
module tb_keypad_scanner;

  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;
  localparam int FRAME    = COLS * SCAN_DIV;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pressed = 16'h0000;
  logic [3:0]  rows_s;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state (frame level).
  bit       m_held;
  bit       m_valid;
  bit       m_multi;
  int       m_code;
  int       m_streak_code;
  int       m_streak_len;
  int       m_none_len;

  typedef struct {
    logic [15:0] keys;
    logic        valid;
    logic        held;
    logic [3:0]  code;
    logic        multi;
  } vec_t;

  vec_t tbl[$];

  keypad_if #(.ROWS(ROWS), .COLS(COLS)) kp();

  keypad_scanner #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .SCAN_DIV (SCAN_DIV),
    .DEBOUNCE (DEBOUNCE)
  ) dut (
    .clock (clock),
    .reset (reset),
    .kp    (kp)
  );

  always #5 clock = ~clock;

  // Keypad: a row reads low when a pressed key sits in a strobed column.
  always_comb begin
    rows_s = 4'b1111;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (!kp.col_n[c] && pressed[r*COLS + c]) rows_s[r] = 1'b0;
      end
    end
  end
  assign kp.row_n = rows_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_held = 1'b0; m_valid = 1'b0; m_multi = 1'b0; m_code = 0;
    m_streak_code = 0; m_streak_len = 0; m_none_len = 0;
  endtask

  // One frame's worth of keys: classify, then apply press/release streak rules.
  task automatic model_frame(input logic [15:0] keys);
    int n;
    int c;
    n = $countones(keys);
    c = 0;
    for (int k = 0; k < 16; k++) if (keys[k]) c = k;
    m_valid = 1'b0;
    m_multi = (n >= 2);
    if (!m_held) begin
      if (n == 1) begin
        m_streak_len  = (m_streak_len > 0 && m_streak_code == c) ? m_streak_len + 1 : 1;
        m_streak_code = c;
        if (m_streak_len == DEBOUNCE) begin
          m_held = 1'b1; m_valid = 1'b1; m_code = c; m_none_len = 0;
        end
      end else begin
        m_streak_len = 0;
      end
    end else begin
      if (n == 0) begin
        m_none_len++;
        if (m_none_len == DEBOUNCE) begin
          m_held = 1'b0; m_streak_len = 0;
        end
      end else begin
        m_none_len = 0;
      end
    end
  endtask

  // Compare every output against the model at cycle position i of a frame.
  task automatic check_cycle(input int i);
    logic [3:0] ecol;
    logic [3:0] one;
    one  = 4'b0001;
    ecol = ~(one << (i / SCAN_DIV));
    check("col_n", kp.col_n, ecol);
    check("key_valid", kp.key_valid, (i == 0) ? m_valid : 1'b0);
    check("key_held", kp.key_held, m_held);
    check("key_code", kp.key_code, m_code);
    check("multi_key", kp.multi_key, m_multi);
  endtask

  // Called at a negedge on a frame start; leaves at the next frame start.
  task automatic run_frame(input logic [15:0] keys);
    pressed = keys;
    for (int i = 0; i < FRAME; i++) begin
      check_cycle(i);
      @(posedge clock);
      @(negedge clock);
    end
    model_frame(keys);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    check("rst_col_n", kp.col_n, 4'b1110);
    check("rst_key_valid", kp.key_valid, 1'b0);
    check("rst_key_held", kp.key_held, 1'b0);
    check("rst_key_code", kp.key_code, 4'd0);
    check("rst_multi_key", kp.multi_key, 1'b0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  // Part of a frame followed by a reset; the partial frame is discarded.
  task automatic partial_then_reset(input logic [15:0] keys, input int ncyc);
    pressed = keys;
    for (int i = 0; i < ncyc; i++) begin
      check_cycle(i);
      @(posedge clock);
      @(negedge clock);
    end
    apply_reset();
  endtask

  task automatic add(input logic [15:0] k, input logic v, input logic h,
                     input logic [3:0] c, input logic m);
    vec_t e;
    e.keys = k; e.valid = v; e.held = h; e.code = c; e.multi = m;
    tbl.push_back(e);
  endtask

  initial begin
    logic [15:0] k9, k14, k5, kn;
    k9  = 16'h0200;
    k14 = 16'h4000;
    k5  = 16'h0020;
    kn  = 16'h0000;

    // Key 9 held for 10 frames, then released.
    add(k9, 1'b0, 1'b0, 4'd0, 1'b0);
    add(k9, 1'b0, 1'b0, 4'd0, 1'b0);
    add(k9, 1'b1, 1'b1, 4'd9, 1'b0);
    for (int i = 0; i < 7; i++) add(k9, 1'b0, 1'b1, 4'd9, 1'b0);
    add(kn, 1'b0, 1'b1, 4'd9, 1'b0);
    add(kn, 1'b0, 1'b1, 4'd9, 1'b0);
    add(kn, 1'b0, 1'b0, 4'd9, 1'b0);
    // Alternating press/none never debounces.
    add(k9, 1'b0, 1'b0, 4'd9, 1'b0);
    add(kn, 1'b0, 1'b0, 4'd9, 1'b0);
    add(k9, 1'b0, 1'b0, 4'd9, 1'b0);
    add(kn, 1'b0, 1'b0, 4'd9, 1'b0);
    // Keys 9 and 14 together, then 14 released.
    for (int i = 0; i < 3; i++) add(k9 | k14, 1'b0, 1'b0, 4'd9, 1'b1);
    add(k9, 1'b0, 1'b0, 4'd9, 1'b0);
    add(k9, 1'b0, 1'b0, 4'd9, 1'b0);
    add(k9, 1'b1, 1'b1, 4'd9, 1'b0);
    add(kn, 1'b0, 1'b1, 4'd9, 1'b0);
    add(kn, 1'b0, 1'b1, 4'd9, 1'b0);
    add(kn, 1'b0, 1'b0, 4'd9, 1'b0);
    // Key 5 accepted, short release, re-press: no second strobe.
    add(k5, 1'b0, 1'b0, 4'd9, 1'b0);
    add(k5, 1'b0, 1'b0, 4'd9, 1'b0);
    add(k5, 1'b1, 1'b1, 4'd5, 1'b0);
    add(kn, 1'b0, 1'b1, 4'd5, 1'b0);
    add(kn, 1'b0, 1'b1, 4'd5, 1'b0);
    add(k5, 1'b0, 1'b1, 4'd5, 1'b0);
    add(k5, 1'b0, 1'b1, 4'd5, 1'b0);

    @(negedge clock);
    apply_reset();

    // Reset in the middle of a frame.
    run_frame(kn);
    partial_then_reset(k9, 9);

    for (int j = 0; j < tbl.size(); j++) begin
      run_frame(tbl[j].keys);
      check("tbl_key_valid", kp.key_valid, tbl[j].valid);
      check("tbl_key_held", kp.key_held, tbl[j].held);
      check("tbl_key_code", kp.key_code, tbl[j].code);
      check("tbl_multi_key", kp.multi_key, tbl[j].multi);
    end

    // Key 5 still held across a reset: fresh debounce and a fresh strobe.
    partial_then_reset(k5, 7);
    run_frame(k5);
    check("rp1_key_valid", kp.key_valid, 1'b0);
    check("rp1_key_held", kp.key_held, 1'b0);
    run_frame(k5);
    check("rp2_key_valid", kp.key_valid, 1'b0);
    run_frame(k5);
    check("rp3_key_valid", kp.key_valid, 1'b1);
    check("rp3_key_code", kp.key_code, 4'd5);
    check("rp3_key_held", kp.key_held, 1'b1);
    run_frame(k5);
    check("rp4_key_valid", kp.key_valid, 1'b0);
    run_frame(kn);
    run_frame(kn);
    run_frame(kn);
    check("rp_release_held", kp.key_held, 1'b0);

    // Random key patterns held for random runs of frames.
    for (int run = 0; run < 40; run++) begin
      logic [15:0] keys;
      int sel;
      int k1;
      int k2;
      int len;
      sel = $urandom_range(0, 9);
      k1  = $urandom_range(0, 15);
      k2  = (k1 + 1 + $urandom_range(0, 14)) % 16;
      keys = 16'h0000;
      if (sel >= 3) keys[k1] = 1'b1;
      if (sel >= 8) keys[k2] = 1'b1;
      len = $urandom_range(1, 5);
      if ($urandom_range(0, 9) == 0) partial_then_reset(keys, $urandom_range(1, FRAME - 1));
      for (int f = 0; f < len; f++) run_frame(keys);
    end
    run_frame(16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
